bp_me_mem_multi_model: RTL and testbench

//  Multi-channel, fixed-latency block memory model for ME testbenches; successor to the single-CCE memory.

---
 rtl/bp_me_mem_multi_model_pkg.sv | 24 ++
 rtl/bp_me_mem_multi_model_if.sv | 43 ++++
 rtl/bp_me_mem_multi_model_arb.sv | 50 +++++
 rtl/bp_me_mem_multi_model.sv | 188 ++++++++++++++++++
 tb/tb_bp_me_mem_multi_model.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/bp_me_mem_multi_model_pkg.sv
// Shared definitions for the multi-channel block memory model.
//
// Contents:
//   state_e   - controller state (eINIT preload, eREADY idle, eWAIT latency, eRESP response)
//   lg_bytes  - log2 of the number of bytes in one block
//   lg_els    - log2 of the backing-store depth
package bp_me_mem_model_pkg;

    typedef enum logic [1:0] {
        eINIT  = 2'd0,
        eREADY = 2'd1,
        eWAIT  = 2'd2,
        eRESP  = 2'd3
    } state_e;

    function automatic int lg_bytes(input int block_width);
        return $clog2(block_width / 8);
    endfunction

    function automatic int lg_els(input int mem_els);
        return $clog2(mem_els);
    endfunction

endpackage

// File: rtl/bp_me_mem_multi_model_if.sv
// Signal bundle between the CCE memory channels / boot ROM and the memory model.
//
// Handshake semantics:
//   Command: a channel raises cmd_v_i[k] with its fields and keeps them stable until it
//   sees cmd_yumi_o[k]; the command is consumed on the clock edge that ends the yumi cycle.
//   Response: resp_v_o[k] with resp_we_o/resp_data_o stays asserted and stable until
//   resp_ready_i[k] is high in the same cycle; that edge completes the transfer.
//
// Modports:
//   slave  - memory model side (drives yumi, response, boot ROM address, init_done)
//   master - channel/testbench side (drives commands, response ready, boot ROM data)
interface bp_me_mem_multi_model_if #(
    parameter int num_chan_p     = 2,
    parameter int addr_width_p   = 22,
    parameter int block_width_p  = 512,
    parameter int boot_rom_els_p = 512
);
    localparam int boot_addr_w_lp = $clog2(boot_rom_els_p);

    logic [num_chan_p-1:0]               cmd_v_i;
    logic [num_chan_p-1:0]               cmd_we_i;
    logic [num_chan_p*addr_width_p-1:0]  cmd_addr_i;
    logic [num_chan_p*block_width_p-1:0] cmd_data_i;
    logic [num_chan_p-1:0]               cmd_yumi_o;
    logic [num_chan_p-1:0]               resp_v_o;
    logic                                resp_we_o;
    logic [block_width_p-1:0]            resp_data_o;
    logic [num_chan_p-1:0]               resp_ready_i;
    logic [boot_addr_w_lp-1:0]           boot_rom_addr_o;
    logic [block_width_p-1:0]            boot_rom_data_i;
    logic                                init_done_o;

    modport slave (
        input  cmd_v_i, cmd_we_i, cmd_addr_i, cmd_data_i, resp_ready_i, boot_rom_data_i,
        output cmd_yumi_o, resp_v_o, resp_we_o, resp_data_o, boot_rom_addr_o, init_done_o
    );

    modport master (
        output cmd_v_i, cmd_we_i, cmd_addr_i, cmd_data_i, resp_ready_i, boot_rom_data_i,
        input  cmd_yumi_o, resp_v_o, resp_we_o, resp_data_o, boot_rom_addr_o, init_done_o
    );

endinterface

// File: rtl/bp_me_mem_multi_model_arb.sv
// Round-robin arbiter for the memory model command channels.
//
// Ports:
//   clk_i, reset_i - clock, synchronous active-high reset (pointer returns to channel 0)
//   v_i            - per-channel request
//   grant_en_i     - grants are only issued (and the pointer only moves) while high
//   grant_o        - one-hot grant, combinational from v_i and the pointer
module bp_me_rr_arb #(
    parameter int num_chan_p = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [num_chan_p-1:0] v_i,
    input  logic                  grant_en_i,
    output logic [num_chan_p-1:0] grant_o
);
    localparam int ptr_w_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;

    logic [ptr_w_lp-1:0] ptr_r;
    logic [ptr_w_lp-1:0] ptr_next;
    logic                found;
    int                  idx;

    // Search upward from the pointer, wrapping; the first requester wins and the
    // pointer moves to the channel just past it.
    always_comb begin
        grant_o  = '0;
        found    = 1'b0;
        ptr_next = ptr_r;
        idx      = 0;
        for (int i = 0; i < num_chan_p; i++) begin
            idx = int'(ptr_r) + i;
            if (idx >= num_chan_p) idx = idx - num_chan_p;
            if (!found && v_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = grant_en_i;
                ptr_next     = (idx == num_chan_p - 1) ? '0 : ptr_w_lp'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_r <= '0;
        end else if (grant_en_i && found) begin
            ptr_r <= ptr_next;
        end
    end

endmodule

// File: rtl/bp_me_mem_multi_model.sv
// Multi-channel fixed-latency block memory model for ME testbenches.
// Several CCE memory channels share one backing store through a round-robin
// arbiter; one command is outstanding at a time.
//
// Optional feature macro: BP_ME_MEM_BOOT_INIT_EN
//   defined   - after reset the store is preloaded from the boot ROM (eINIT), one block per cycle
//   undefined - reset goes straight to eREADY, boot ROM address tied to 0, store left uninitialised
//
// Ports:
//   clk_i   - clock
//   reset_i - synchronous active-high reset; drops any in-flight command
//   bus     - slave modport: commands, yumi, responses, boot ROM port, init_done
//   state_o - current controller state, for observation
module bp_me_mem_multi_model
    import bp_me_mem_model_pkg::*;
#(
    parameter int num_chan_p     = 2,
    parameter int addr_width_p   = 22,
    parameter int block_width_p  = 512,
    parameter int mem_els_p      = 512,
    parameter int latency_p      = 4,
    parameter int boot_rom_els_p = 512
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    bp_me_mem_multi_model_if.slave   bus,
    output state_e                   state_o
);
    localparam int lg_bytes_lp = lg_bytes(block_width_p);
    localparam int lg_els_lp   = lg_els(mem_els_p);
    localparam int chan_w_lp   = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;
    localparam int cnt_w_lp    = (latency_p > 1) ? $clog2(latency_p) : 1;

    state_e                     state_r;
    logic [cnt_w_lp-1:0]        cnt_r;
    logic [chan_w_lp-1:0]       winner_r;
    logic                       resp_v_r;
    logic                       resp_we_r;
    logic [block_width_p-1:0]   resp_data_r;
    logic                       init_done_r;

    logic [block_width_p-1:0]   mem [mem_els_p];

    logic                       grant_en;
    logic [num_chan_p-1:0]      grant;
    logic                       any_grant;
    logic [chan_w_lp-1:0]       grant_id;
    logic                       sel_we;
    logic [lg_els_lp-1:0]       sel_idx;
    logic [block_width_p-1:0]   sel_data;
    logic [num_chan_p-1:0]      resp_v_vec;

    // Grants only in eREADY after init and never while reset is asserted,
    // so yumi is low on every reset cycle even with commands pending.
    assign grant_en = (state_r == eREADY) && init_done_r && !reset_i;

    bp_me_rr_arb #(.num_chan_p(num_chan_p)) u_arb (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .v_i        (bus.cmd_v_i),
        .grant_en_i (grant_en),
        .grant_o    (grant)
    );

    assign any_grant = |grant;

    // Select the granted channel's command fields. Only the block-index slice of
    // the address is used, so high address bits wrap modulo mem_els_p.
    always_comb begin
        grant_id = '0;
        sel_we   = 1'b0;
        sel_idx  = '0;
        sel_data = '0;
        for (int k = 0; k < num_chan_p; k++) begin
            if (grant[k]) begin
                grant_id = chan_w_lp'(k);
                sel_we   = bus.cmd_we_i[k];
                sel_idx  = bus.cmd_addr_i[k*addr_width_p + lg_bytes_lp +: lg_els_lp];
                sel_data = bus.cmd_data_i[k*block_width_p +: block_width_p];
            end
        end
    end

    always_comb begin
        resp_v_vec = '0;
        for (int k = 0; k < num_chan_p; k++) begin
            resp_v_vec[k] = resp_v_r && (winner_r == chan_w_lp'(k));
        end
    end

`ifdef BP_ME_MEM_BOOT_INIT_EN
    localparam int boot_addr_w_lp = $clog2(boot_rom_els_p);
    localparam int init_els_lp    = (boot_rom_els_p < mem_els_p) ? boot_rom_els_p : mem_els_p;

    logic [boot_addr_w_lp-1:0] boot_addr_r;

    always_ff @(posedge clk_i) begin
        if (!reset_i && state_r == eINIT) begin
            mem[lg_els_lp'(boot_addr_r)] <= bus.boot_rom_data_i;
        end else if (any_grant && sel_we) begin
            mem[sel_idx] <= sel_data;
        end
    end

    assign bus.boot_rom_addr_o = boot_addr_r;
`else
    always_ff @(posedge clk_i) begin
        if (any_grant && sel_we) begin
            mem[sel_idx] <= sel_data;
        end
    end

    assign bus.boot_rom_addr_o = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
`ifdef BP_ME_MEM_BOOT_INIT_EN
            state_r     <= eINIT;
            boot_addr_r <= '0;
`else
            state_r     <= eREADY;
`endif
            cnt_r       <= '0;
            winner_r    <= '0;
            resp_v_r    <= 1'b0;
            resp_we_r   <= 1'b0;
            resp_data_r <= '0;
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                eINIT: begin
`ifdef BP_ME_MEM_BOOT_INIT_EN
                    if (boot_addr_r == boot_addr_w_lp'(init_els_lp - 1)) begin
                        state_r     <= eREADY;
                        init_done_r <= 1'b1;
                    end else begin
                        boot_addr_r <= boot_addr_r + 1'b1;
                    end
`else
                    state_r     <= eREADY;
                    init_done_r <= 1'b1;
`endif
                end
                eREADY: begin
                    // Without preload, init_done rises one cycle after reset release.
                    init_done_r <= 1'b1;
                    if (any_grant) begin
                        winner_r    <= grant_id;
                        resp_we_r   <= sel_we;
                        // Read data is the pre-edge contents; writes echo their data.
                        resp_data_r <= sel_we ? sel_data : mem[sel_idx];
                        if (latency_p == 0) begin
                            state_r  <= eRESP;
                            resp_v_r <= 1'b1;
                        end else begin
                            state_r <= eWAIT;
                            cnt_r   <= cnt_w_lp'(latency_p - 1);
                        end
                    end
                end
                eWAIT: begin
                    if (cnt_r == '0) begin
                        state_r  <= eRESP;
                        resp_v_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                eRESP: begin
                    if (bus.resp_ready_i[winner_r]) begin
                        resp_v_r <= 1'b0;
                        state_r  <= eREADY;
                    end
                end
                default: state_r <= eREADY;
            endcase
        end
    end

    assign bus.cmd_yumi_o  = grant;
    assign bus.resp_v_o    = resp_v_vec;
    assign bus.resp_we_o   = resp_we_r;
    assign bus.resp_data_o = resp_data_r;
    assign bus.init_done_o = init_done_r;
    assign state_o         = state_r;

endmodule

// File: tb/tb_bp_me_mem_multi_model.sv
// Directed testbench for bp_me_mem_multi_model (2 channels, 64-block store,
// latency 4, boot ROM word i = i). Works with or without BP_ME_MEM_BOOT_INIT_EN;
// without preload, block 1 is written with 1 before it is read.
module tb_bp_me_mem_multi_model;
    import bp_me_mem_model_pkg::*;

    localparam int N    = 2;
    localparam int AW   = 22;
    localparam int BW   = 512;
    localparam int ELS  = 64;
    localparam int LAT  = 4;
    localparam int BOOT = 64;

    logic   clk = 1'b0;
    logic   reset;
    state_e state;
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bp_me_mem_multi_model_if #(
        .num_chan_p(N), .addr_width_p(AW), .block_width_p(BW), .boot_rom_els_p(BOOT)
    ) bus ();

    bp_me_mem_multi_model #(
        .num_chan_p(N), .addr_width_p(AW), .block_width_p(BW),
        .mem_els_p(ELS), .latency_p(LAT), .boot_rom_els_p(BOOT)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus.slave),
        .state_o (state)
    );

    // Boot ROM model: word i holds the value i.
    assign bus.boot_rom_data_i = BW'(bus.boot_rom_addr_o);

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command on channel ch and wait for its yumi; returns the yumi cycle.
    task automatic issue(input int ch, input logic we, input logic [AW-1:0] addr,
                         input logic [BW-1:0] data, output int yc);
        bus.cmd_we_i[ch]                = we;
        bus.cmd_addr_i[ch*AW +: AW]     = addr;
        bus.cmd_data_i[ch*BW +: BW]     = data;
        bus.cmd_v_i[ch]                 = 1'b1;
        #1;
        yc = -1;
        for (int i = 0; i < 300 && yc < 0; i++) begin
            if (bus.cmd_yumi_o[ch]) yc = cyc;
            else tick();
        end
        check("yumi_seen", BW'(yc >= 0), BW'(1));
        check("yumi_onehot", BW'(bus.cmd_yumi_o), BW'(1 << ch));
        tick();
        bus.cmd_v_i[ch] = 1'b0;
    endtask

    // Wait for the response on ch and check latency and contents.
    task automatic wait_resp(input string tag, input int ch, input int yc,
                             input logic we, input logic [BW-1:0] data);
        int rc;
        rc = -1;
        for (int i = 0; i < 300 && rc < 0; i++) begin
            if (bus.resp_v_o[ch]) rc = cyc;
            else tick();
        end
        check({tag, "_lat"}, BW'(rc), BW'(yc + 1 + LAT));
        check({tag, "_v"}, BW'(bus.resp_v_o), BW'(1 << ch));
        check({tag, "_we"}, BW'(bus.resp_we_o), BW'(we));
        check({tag, "_data"}, bus.resp_data_o, data);
    endtask

    // With resp_ready high, the handshake completes on the next edge.
    task automatic finish_resp(input string tag);
        tick();
        check({tag, "_v_clear"}, BW'(bus.resp_v_o), BW'(0));
    endtask

    initial begin
        logic [BW-1:0] pat_aa;
        logic [BW-1:0] one;
        state_e        reset_state;
        int            yc;
        int            r;
        int            exp_order [4];
        int            s0;
        int            s1;
        int            g;
        logic          any_v;

        pat_aa = {64{8'hAA}};
        one    = BW'(1);
        exp_order = '{0, 1, 0, 1};
`ifdef BP_ME_MEM_BOOT_INIT_EN
        reset_state = eINIT;
`else
        reset_state = eREADY;
`endif

        // Clock/reset
        reset            = 1'b1;
        bus.cmd_v_i      = '0;
        bus.cmd_we_i     = '0;
        bus.cmd_addr_i   = '0;
        bus.cmd_data_i   = '0;
        bus.resp_ready_i = 2'b11;
        repeat (3) tick();

        check("rst_yumi", BW'(bus.cmd_yumi_o), BW'(0));
        check("rst_resp_v", BW'(bus.resp_v_o), BW'(0));
        check("rst_resp_we", BW'(bus.resp_we_o), BW'(0));
        check("rst_resp_data", bus.resp_data_o, BW'(0));
        check("rst_boot_addr", BW'(bus.boot_rom_addr_o), BW'(0));
        check("rst_init_done", BW'(bus.init_done_o), BW'(0));
        check("rst_state", BW'(state), BW'(reset_state));

        reset = 1'b0;
        r = cyc;

        // 1. Preload / first read. The command is raised while init is still running.
`ifdef BP_ME_MEM_BOOT_INIT_EN
        issue(0, 1'b0, 22'h40, '0, yc);
        check("t1_pending_yumi_cycle", BW'(yc), BW'(r + BOOT));
        wait_resp("t1_read", 0, yc, 1'b0, one);
        finish_resp("t1");
`else
        issue(0, 1'b1, 22'h40, one, yc);
        check("t1_first_yumi_cycle", BW'(yc), BW'(r + 1));
        wait_resp("t1_wr", 0, yc, 1'b1, one);
        finish_resp("t1_wr");
        issue(0, 1'b0, 22'h40, '0, yc);
        wait_resp("t1_read", 0, yc, 1'b0, one);
        finish_resp("t1");
`endif
        check("t1_init_done", BW'(bus.init_done_o), BW'(1));

        // 2. Read after write on ch1
        issue(1, 1'b1, 22'h80, pat_aa, yc);
        wait_resp("t2_wr", 1, yc, 1'b1, pat_aa);
        finish_resp("t2_wr");
        issue(1, 1'b0, 22'h80, '0, yc);
        wait_resp("t2_rd", 1, yc, 1'b0, pat_aa);
        finish_resp("t2_rd");

        // 3. Fairness: both channels request two reads each
        bus.cmd_we_i            = 2'b00;
        bus.cmd_addr_i[0 +: AW]  = 22'h40;
        bus.cmd_addr_i[AW +: AW] = 22'h80;
        bus.cmd_v_i             = 2'b11;
        #1;
        s0 = 0;
        s1 = 0;
        for (int n = 0; n < 4; n++) begin
            g = -1;
            for (int i = 0; i < 100 && g < 0; i++) begin
                if (bus.cmd_yumi_o == 2'b01) g = 0;
                else if (bus.cmd_yumi_o == 2'b10) g = 1;
                else tick();
            end
            check($sformatf("t3_grant%0d", n), BW'(g), BW'(exp_order[n]));
            if (g == 0) s0++;
            if (g == 1) s1++;
            tick();
            if (s0 == 2) bus.cmd_v_i[0] = 1'b0;
            if (s1 == 2) bus.cmd_v_i[1] = 1'b0;
        end
        bus.cmd_v_i = 2'b00;
        repeat (8) tick();
        check("t3_idle", BW'(state), BW'(eREADY));

        // 4. Backpressure on ch0 while ch1 has a command pending
        bus.resp_ready_i = 2'b10;
        issue(0, 1'b0, 22'h40, '0, yc);
        bus.cmd_we_i[1]          = 1'b0;
        bus.cmd_addr_i[AW +: AW] = 22'h80;
        bus.cmd_v_i[1]           = 1'b1;
        wait_resp("t4", 0, yc, 1'b0, one);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t4_hold_v%0d", i), BW'(bus.resp_v_o), BW'(2'b01));
            check($sformatf("t4_hold_data%0d", i), bus.resp_data_o, one);
            check($sformatf("t4_hold_noyumi%0d", i), BW'(bus.cmd_yumi_o), BW'(0));
            tick();
        end
        bus.resp_ready_i[0] = 1'b1;
        #1;
        check("t4_hs_noyumi", BW'(bus.cmd_yumi_o), BW'(0));
        finish_resp("t4");
        issue(1, 1'b0, 22'h80, '0, yc);
        wait_resp("t4_ch1", 1, yc, 1'b0, pat_aa);
        finish_resp("t4_ch1");

        // 5. Address wrap: block ELS+1 aliases block 1
        issue(0, 1'b0, 22'(ELS * 64 + 'h40), '0, yc);
        wait_resp("t5_wrap", 0, yc, 1'b0, one);
        finish_resp("t5");

        // 6. Reset while waiting on the latency counter
        issue(0, 1'b0, 22'h80, '0, yc);
        check("t6_in_wait", BW'(state), BW'(eWAIT));
        reset = 1'b1;
        tick();
        check("t6_rst_state", BW'(state), BW'(reset_state));
        check("t6_rst_init_done", BW'(bus.init_done_o), BW'(0));
        check("t6_rst_resp_v", BW'(bus.resp_v_o), BW'(0));
        check("t6_rst_yumi", BW'(bus.cmd_yumi_o), BW'(0));
        tick();
        reset = 1'b0;
        any_v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            any_v = any_v | (|bus.resp_v_o);
        end
        check("t6_no_stale_resp", BW'(any_v), BW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
